mod_dec_add_round_key: RTL
==========================

MOD_DEC_ADD_ROUND_KEY -- requirements
Module: mod_dec_addRoundKey

Interface
REQ-001 SHALL have parameter NR, default 14: number of AES-256 rounds; round keys are indexed 0..NR.
REQ-002 SHALL have parameter KEY_LAT, default 1: romKey read latency in cycles, legal range 1..4.
REQ-003 SHALL have port clk  input  1: single clock; all logic samples on its rising edge.
REQ-004 SHALL have port resetn  input  1: synchronous, active-high reset (asserted = 1) despite the port name.
REQ-005 SHALL have port in_valid  input  1: the p/in_first inputs are valid.
REQ-006 SHALL have port in_ready  output  1: the block accepts input this cycle.
REQ-007 SHALL have port in_first  input  1: the accepted block is the first round of a new decryption.
REQ-008 SHALL have port p  input  [15:0][7:0]: input state bytes.
REQ-009 SHALL have port key_rd  output  1: read strobe to romKey.
REQ-010 SHALL have port key_addr  output  4: round-key index to romKey.
REQ-011 SHALL have port k  input  128: round key, valid exactly KEY_LAT cycles after key_rd.
REQ-012 SHALL have port o  output  [15:0][7:0]: output state bytes.
REQ-013 SHALL have port out_valid  output  1: o, out_round and out_last are valid.
REQ-014 SHALL have port out_ready  input  1: downstream accepts the output.
REQ-015 SHALL have port out_round  output  4: round-key index applied to o.
REQ-016 SHALL have port out_last  output  1: o used round key 0, so the decryption is complete.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT and HOLD.
REQ-018 SHALL hold in_ready=1 only in IDLE.
REQ-019 SHALL, on an IDLE-state in_valid&in_ready edge, register p and go to FETCH.
REQ-020 SHALL, on that same acceptance edge, load the round counter with NR when in_first=1 and keep it otherwise.
REQ-021 SHALL, in FETCH, drive key_rd=1 for exactly one cycle with key_addr equal to the round counter, then go to WAIT.
REQ-022 SHALL stay in WAIT for KEY_LAT cycles and, on the final WAIT edge, register o[i] = p_reg[i] ^ k[8*i +: 8] for i = 0..15, then go to HOLD.
REQ-023 SHALL, in HOLD, drive out_valid=1 and keep o, out_round and out_last stable until out_ready=1.
REQ-024 SHALL, on the HOLD out_valid&out_ready edge, go to IDLE and decrement the round counter; when out_round=0, it SHALL reload the counter to NR instead of decrementing.
REQ-025 SHALL assert out_last=1 exactly when out_round=0.
REQ-026 SHALL give a latency of KEY_LAT+2 cycles from the acceptance edge to the first out_valid=1 cycle; with zero backpressure, the minimum block interval is KEY_LAT+3 cycles.
REQ-027 SHALL restart the round sequence at NR when in_first=1 arrives mid-sequence (counter below NR), with no error flag.
REQ-028 SHALL never underflow or wrap the round counter below 0.
REQ-029 SHALL drive key_addr only from the counter, so it is always in 0..NR.
REQ-030 SHALL ignore input changes outside IDLE.
REQ-031 SHALL ignore k outside the final WAIT cycle.

Reset
REQ-032 SHALL, with resetn=1 at a clock edge, force state to IDLE and the round counter to NR.
REQ-033 SHALL, with resetn=1 at a clock edge, force o=0, out_valid=0, out_round=NR, out_last=0, key_rd=0, key_addr=0 and in_ready=0 for that cycle.
REQ-034 SHALL let reset override any in-flight FETCH, WAIT or HOLD, discarding that block and issuing no further key_rd for it.
REQ-035 SHALL assert in_ready=1 the cycle after resetn deasserts.

Verification
REQ-036 Bench SHALL cover: p bytes all 0x00, in_first=1, k=0x0F0E...0100 (byte i = i) -> key_addr=14, o[i]=i, out_round=14, out_last=0, out_valid at acceptance+3 (KEY_LAT=1).
REQ-037 Bench SHALL cover: p bytes all 0xFF with k=0 -> o all 0xFF; then p = k = 0xA5 repeated -> o all 0x00.
REQ-038 Bench SHALL cover: 15 consecutive blocks, first with in_first=1 -> key_addr sequence 14,13,...,0, out_last only on the 15th block, and the next block uses key_addr=14.
REQ-039 Bench SHALL cover: out_ready held 0 for 5 cycles in HOLD -> o/out_round stable, in_ready=0, no key_rd; out_ready=1 -> exactly one transfer.
REQ-040 Bench SHALL cover: resetn=1 for one cycle during WAIT -> next cycle out_valid=0 and o=0; the following block with in_first=0 uses key_addr=14.
REQ-041 Bench SHALL cover: in_first=1 on the 6th block (counter=9) -> key_addr=14, out_round=14.

Source files
------------

// File: rtl/mod_dec_add_round_key.sv
// Purpose : AES-256 decryption AddRoundKey stage; fetches the round key from romKey and XORs it into the state.
// Latency : KEY_LAT+2 cycles from input acceptance to out_valid; one block in flight, minimum interval KEY_LAT+3.
// Backpres: out_valid/o/out_round/out_last hold until out_ready; in_ready only while idle.
//
// Ports:
//   clk, resetn          - clock; synchronous reset, active high (asserted = 1)
//   in_valid/in_ready    - input handshake; in_first marks the first round of a new decryption
//   p                    - input state bytes
//   key_rd/key_addr/k    - romKey read strobe, round index, key returned KEY_LAT cycles later
//   o/out_valid/out_ready- output state and handshake
//   out_round/out_last   - round index applied to o; out_last when that index is 0

module mod_dec_add_round_key #(
    parameter int NR      = 14,
    parameter int KEY_LAT = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [15:0][7:0] p,
    output logic             key_rd,
    output logic [3:0]       key_addr,
    input  logic [127:0]     k,
    output logic [15:0][7:0] o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_round,
    output logic             out_last
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    localparam logic [3:0] NR_L      = 4'(NR);
    localparam logic [2:0] WAIT_LAST = 3'(KEY_LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       rnd_cnt;
    logic [2:0]       wait_cnt;
    logic [15:0][7:0] p_reg;
    logic [15:0][7:0] o_reg;
    logic [3:0]       rnd_reg;
    logic             accept;
    logic             load_o;
    logic             xfer;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_o    = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = WAIT;
            WAIT: begin
                // k is only meaningful on the last WAIT cycle, KEY_LAT cycles after key_rd
                if (wait_cnt == WAIT_LAST) begin
                    load_o    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    xfer      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset masks every output combinationally for the cycle it is asserted.
    always_comb begin
        in_ready  = (state == IDLE) && !resetn;
        key_rd    = (state == FETCH) && !resetn;
        key_addr  = resetn ? 4'd0 : rnd_cnt;
        out_valid = (state == HOLD) && !resetn;
        o         = resetn ? '0 : o_reg;
        out_round = resetn ? NR_L : rnd_reg;
        out_last  = !resetn && (rnd_reg == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= IDLE;
            rnd_cnt  <= NR_L;
            wait_cnt <= 3'd0;
            p_reg    <= '0;
            o_reg    <= '0;
            rnd_reg  <= NR_L;
        end else begin
            state <= state_nxt;
            if (accept) begin
                p_reg <= p;
                // a new decryption restarts at the last round key, even mid-sequence
                if (in_first) begin
                    rnd_cnt <= NR_L;
                end
            end
            if (state == FETCH) begin
                wait_cnt <= 3'd0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
            if (load_o) begin
                o_reg   <= p_reg ^ k;
                rnd_reg <= rnd_cnt;
            end
            if (xfer) begin
                // round 0 finishes the decryption; wrap back to NR rather than underflow
                rnd_cnt <= (rnd_cnt == 4'd0) ? NR_L : rnd_cnt - 4'd1;
            end
        end
    end

endmodule
